// File: rtl/nvme_ioq_pkg.sv
// Shared types and constants for the NVMe I/O queue submission path.
package nvme_ioq_pkg;

  localparam int unsigned SQE_BYTES     = 64;
  localparam int unsigned BEATS_PER_SQE = 2;

  typedef enum logic [1:0] {
    DB_IDLE = 2'd0,
    DB_SEND = 2'd1,
    DB_GAP  = 2'd2
  } db_state_e;

  // Doorbell byte offset inside the doorbell region: (2*qid + is_cq) * (4 << stride).
  function automatic logic [31:0] db_offset(input int unsigned qid,
                                            input int unsigned stride,
                                            input logic        is_cq);
    logic [31:0] idx;
    idx = (32'(qid) << 1) | {31'd0, is_cq};
    return idx * (32'd4 << stride);
  endfunction

endpackage

// File: rtl/nvme_sq_ram.sv
// Simple dual-port SQ ring storage: one write port, one registered read port.
module nvme_sq_ram #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [0:(1 << AW)-1];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read samples the pre-write contents, so a colliding write returns old data.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/nvme_ioq_sq_writer.sv
// Assembles 256-bit command beats into 64-byte SQEs, stores them in the SQ ring
// and issues coalesced SQ tail doorbell writes.
module nvme_ioq_sq_writer
  import nvme_ioq_pkg::*;
#(
  parameter int unsigned CSR_DATA_WIDTH = 256,
  parameter int unsigned SQ_DEPTH       = 16,
  parameter int unsigned SQ_ID          = 1,
  parameter int unsigned DB_STRIDE      = 0,
  parameter logic [31:0] DB_BASE        = 32'h0000_1000
) (
  input  logic                        user_clk,
  input  logic                        user_reset,
  input  logic                        user_lnk_up,
  input  logic [CSR_DATA_WIDTH-1:0]   csr_ioq_data,
  input  logic                        csr_ioq_valid,
  output logic                        csr_ioq_ready,
  input  logic                        sq_rd_en,
  input  logic [$clog2(SQ_DEPTH)-1:0] sq_rd_idx,
  input  logic                        sq_rd_beat,
  output logic [CSR_DATA_WIDTH-1:0]   sq_rd_data,
  output logic                        db_valid,
  input  logic                        db_ready,
  output logic [31:0]                 db_addr,
  output logic [31:0]                 db_data,
  input  logic                        cq_sq_head_valid,
  input  logic [$clog2(SQ_DEPTH)-1:0] cq_sq_head,
  output logic                        sq_full,
  output logic                        sq_empty,
  output logic                        overflow_err,
  output logic [15:0]                 cmd_count
);

  localparam int unsigned IW = $clog2(SQ_DEPTH);
  localparam int unsigned AW = IW + $clog2(BEATS_PER_SQE);
  localparam logic [31:0] DB_ADDR = DB_BASE + db_offset(SQ_ID, DB_STRIDE, 1'b0);

  logic [IW-1:0] tail_q, tail_d, head_q, head_d, tail_inc;
  logic          beat_q, beat_d;
  logic [15:0]   cmd_count_q, cmd_count_d;
  logic          overflow_q, overflow_d;
  logic          sq_full_q, sq_full_d, sq_empty_q, sq_empty_d;
  logic          db_pending_q, db_pending_d;
  db_state_e     db_state_q, db_state_d;
  logic [31:0]   db_data_q, db_data_d, db_addr_q, db_addr_d;
  logic          ready, accept, advance;

  always_comb begin
    ready        = user_lnk_up & (beat_q | ~sq_full_q);
    accept       = csr_ioq_valid & ready;
    advance      = accept & beat_q;
    beat_d       = accept ? ~beat_q : beat_q;
    tail_d       = advance ? tail_q + IW'(1) : tail_q;
    head_d       = cq_sq_head_valid ? cq_sq_head : head_q;
    cmd_count_d  = advance ? cmd_count_q + 16'd1 : cmd_count_q;
    overflow_d   = overflow_q | (csr_ioq_valid & ~ready);
    tail_inc     = tail_d + IW'(1);
    sq_full_d    = (tail_inc == head_d);
    sq_empty_d   = (tail_d == head_d);
    db_state_d   = db_state_q;
    db_pending_d = db_pending_q;
    db_data_d    = db_data_q;
    db_addr_d    = db_addr_q;

    unique case (db_state_q)
      DB_IDLE: begin
        if (db_pending_q) begin
          db_data_d    = 32'(tail_q);
          db_addr_d    = DB_ADDR;
          db_pending_d = 1'b0;
          db_state_d   = DB_SEND;
        end
      end
      DB_SEND: if (db_ready) db_state_d = DB_GAP;
      DB_GAP:  db_state_d = DB_IDLE;
      default: db_state_d = DB_IDLE;
    endcase

    // An advance coinciding with capture re-arms pending: capture took the old tail.
    if (advance) db_pending_d = 1'b1;

    if (!user_lnk_up) begin
      beat_d       = 1'b0;
      db_state_d   = DB_IDLE;
      db_pending_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      tail_q       <= '0;
      head_q       <= '0;
      beat_q       <= 1'b0;
      cmd_count_q  <= '0;
      overflow_q   <= 1'b0;
      sq_full_q    <= 1'b0;
      sq_empty_q   <= 1'b1;
      db_pending_q <= 1'b0;
      db_state_q   <= DB_IDLE;
      db_data_q    <= '0;
      db_addr_q    <= '0;
    end else begin
      tail_q       <= tail_d;
      head_q       <= head_d;
      beat_q       <= beat_d;
      cmd_count_q  <= cmd_count_d;
      overflow_q   <= overflow_d;
      sq_full_q    <= sq_full_d;
      sq_empty_q   <= sq_empty_d;
      db_pending_q <= db_pending_d;
      db_state_q   <= db_state_d;
      db_data_q    <= db_data_d;
      db_addr_q    <= db_addr_d;
    end
  end

  nvme_sq_ram #(
    .DATA_W (CSR_DATA_WIDTH),
    .AW     (AW)
  ) u_ram (
    .clk     (user_clk),
    .rst     (user_reset),
    .wr_en   (accept),
    .wr_addr ({tail_q, beat_q}),
    .wr_data (csr_ioq_data),
    .rd_en   (sq_rd_en),
    .rd_addr ({sq_rd_idx, sq_rd_beat}),
    .rd_data (sq_rd_data)
  );

  assign csr_ioq_ready = ready;
  assign db_valid      = (db_state_q == DB_SEND);
  assign db_addr       = db_addr_q;
  assign db_data       = db_data_q;
  assign sq_full       = sq_full_q;
  assign sq_empty      = sq_empty_q;
  assign overflow_err  = overflow_q;
  assign cmd_count     = cmd_count_q;

endmodule

// File: tb/tb_nvme_ioq_sq_writer.sv
// Directed self-checking bench for nvme_ioq_sq_writer (default parameters).
module tb_nvme_ioq_sq_writer;

  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lnk = 1'b0;
  logic [255:0]  csr_ioq_data = '0;
  logic          csr_ioq_valid = 1'b0;
  logic          csr_ioq_ready;
  logic          sq_rd_en = 1'b0;
  logic [IW-1:0] sq_rd_idx = '0;
  logic          sq_rd_beat = 1'b0;
  logic [255:0]  sq_rd_data;
  logic          db_valid;
  logic          db_ready = 1'b0;
  logic [31:0]   db_addr, db_data;
  logic          cq_sq_head_valid = 1'b0;
  logic [IW-1:0] cq_sq_head = '0;
  logic          sq_full, sq_empty, overflow_err;
  logic [15:0]   cmd_count;

  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;

  nvme_ioq_sq_writer #(
    .CSR_DATA_WIDTH (256),
    .SQ_DEPTH       (16),
    .SQ_ID          (1),
    .DB_STRIDE      (0),
    .DB_BASE        (32'h0000_1000)
  ) dut (
    .user_clk         (clk),
    .user_reset       (rst),
    .user_lnk_up      (lnk),
    .csr_ioq_data     (csr_ioq_data),
    .csr_ioq_valid    (csr_ioq_valid),
    .csr_ioq_ready    (csr_ioq_ready),
    .sq_rd_en         (sq_rd_en),
    .sq_rd_idx        (sq_rd_idx),
    .sq_rd_beat       (sq_rd_beat),
    .sq_rd_data       (sq_rd_data),
    .db_valid         (db_valid),
    .db_ready         (db_ready),
    .db_addr          (db_addr),
    .db_data          (db_data),
    .cq_sq_head_valid (cq_sq_head_valid),
    .cq_sq_head       (cq_sq_head),
    .sq_full          (sq_full),
    .sq_empty         (sq_empty),
    .overflow_err     (overflow_err),
    .cmd_count        (cmd_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input int unsigned s);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'(s * 16 + i) ^ 32'hA5A5_0000;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [255:0] d);
    csr_ioq_valid = 1'b1;
    csr_ioq_data  = d;
    tick();
    csr_ioq_valid = 1'b0;
  endtask

  task automatic send_sqe(input int unsigned s);
    send_beat(pat(s));
    send_beat(pat(s + 1));
  endtask

  task automatic do_read(input logic [IW-1:0] idx, input logic beat, output logic [255:0] d);
    sq_rd_en   = 1'b1;
    sq_rd_idx  = idx;
    sq_rd_beat = beat;
    tick();
    sq_rd_en = 1'b0;
    d = sq_rd_data;
  endtask

  // Waits (bounded) for a doorbell, checks it, completes the handshake and checks the GAP cycle.
  task automatic wait_db(input logic [31:0] exp_data);
    int unsigned n = 0;
    while (!db_valid && n < 20) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (db_valid !== 1'b1) $display("FAIL db_timeout: db_valid=%b required 1 (tail %0d)", db_valid, exp_data);
    else pass_cnt++;
    chk_cnt++;
    if (db_data !== exp_data) $display("FAIL db_data: got %0d required %0d", db_data, exp_data);
    else pass_cnt++;
    chk_cnt++;
    if (db_addr !== 32'h0000_1008) $display("FAIL db_addr: got %h required 00001008", db_addr);
    else pass_cnt++;
    db_ready = 1'b1;
    tick();
    db_ready = 1'b0;
    chk_cnt++;
    if (db_valid !== 1'b0) $display("FAIL db_gap: db_valid=%b required 0", db_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    chk_cnt++;
    if (sq_empty !== 1'b1) $display("FAIL rst_empty: got %b required 1", sq_empty); else pass_cnt++;
    chk_cnt++;
    if ({sq_full, overflow_err, db_valid, csr_ioq_ready} !== 4'b0)
      $display("FAIL rst_flags: full/ovf/dbv/rdy=%b required 0000", {sq_full, overflow_err, db_valid, csr_ioq_ready});
    else pass_cnt++;
    chk_cnt++;
    if ({cmd_count, db_data, db_addr} !== 80'd0)
      $display("FAIL rst_values: cmd=%0d db_data=%h db_addr=%h required 0", cmd_count, db_data, db_addr);
    else pass_cnt++;
    chk_cnt++;
    if (sq_rd_data !== 256'd0) $display("FAIL rst_rd_data: got %h required 0", sq_rd_data); else pass_cnt++;
    rst = 1'b0;
    lnk = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [255:0] d;
    send_sqe(0);
    chk_cnt++;
    if (cmd_count !== 16'd1) $display("FAIL basic_cmd: got %0d required 1", cmd_count); else pass_cnt++;
    chk_cnt++;
    if (sq_empty !== 1'b0) $display("FAIL basic_empty: got %b required 0", sq_empty); else pass_cnt++;
    wait_db(32'd1);
    do_read(4'd0, 1'b0, d);
    chk_cnt++;
    if (d !== pat(0)) $display("FAIL basic_rd0: got %h required %h", d, pat(0)); else pass_cnt++;
    do_read(4'd0, 1'b1, d);
    chk_cnt++;
    if (d !== pat(1)) $display("FAIL basic_rd1: got %h required %h", d, pat(1)); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [255:0] d;
    for (int i = 1; i <= 14; i++) send_sqe(100 + 2 * i);
    chk_cnt++;
    if (sq_full !== 1'b1) $display("FAIL fill_full: got %b required 1", sq_full); else pass_cnt++;
    chk_cnt++;
    if (csr_ioq_ready !== 1'b0) $display("FAIL fill_ready: got %b required 0", csr_ioq_ready); else pass_cnt++;
    chk_cnt++;
    if (cmd_count !== 16'd15) $display("FAIL fill_cmd: got %0d required 15", cmd_count); else pass_cnt++;
    send_beat(pat(999));
    chk_cnt++;
    if (overflow_err !== 1'b1) $display("FAIL fill_overflow: got %b required 1", overflow_err); else pass_cnt++;
    do_read(4'd14, 1'b1, d);
    chk_cnt++;
    if (d !== pat(129)) $display("FAIL fill_rd14: got %h required %h", d, pat(129)); else pass_cnt++;
    wait_db(32'd2);
    wait_db(32'd15);
  endtask

  task automatic test_head_update();
    logic [255:0] d;
    cq_sq_head_valid = 1'b1;
    cq_sq_head       = 4'd5;
    tick();
    cq_sq_head_valid = 1'b0;
    chk_cnt++;
    if (sq_full !== 1'b0) $display("FAIL head_full: got %b required 0", sq_full); else pass_cnt++;
    chk_cnt++;
    if (csr_ioq_ready !== 1'b1) $display("FAIL head_ready: got %b required 1", csr_ioq_ready); else pass_cnt++;
    chk_cnt++;
    if (overflow_err !== 1'b1) $display("FAIL head_ovf_sticky: got %b required 1", overflow_err); else pass_cnt++;
    send_sqe(200);
    chk_cnt++;
    if (cmd_count !== 16'd16) $display("FAIL head_cmd: got %0d required 16", cmd_count); else pass_cnt++;
    wait_db(32'd0);
    do_read(4'd15, 1'b0, d);
    chk_cnt++;
    if (d !== pat(200)) $display("FAIL head_rd15b0: got %h required %h", d, pat(200)); else pass_cnt++;
    do_read(4'd15, 1'b1, d);
    chk_cnt++;
    if (d !== pat(201)) $display("FAIL head_rd15b1: got %h required %h", d, pat(201)); else pass_cnt++;
  endtask

  task automatic test_coalesce();
    logic [255:0] d;
    logic stable = 1'b1;
    int unsigned n = 0;
    cq_sq_head_valid = 1'b1;
    cq_sq_head       = 4'd0;
    tick();
    cq_sq_head_valid = 1'b0;
    chk_cnt++;
    if (sq_empty !== 1'b1) $display("FAIL coal_empty: got %b required 1", sq_empty); else pass_cnt++;
    send_sqe(300);
    while (!db_valid && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      send_beat(pat(302 + 2 * k));
      if (db_valid !== 1'b1 || db_data !== 32'd1) stable = 1'b0;
      send_beat(pat(303 + 2 * k));
      if (db_valid !== 1'b1 || db_data !== 32'd1) stable = 1'b0;
    end
    chk_cnt++;
    if (stable !== 1'b1) $display("FAIL coal_stable: db_valid=%b db_data=%0d required 1/1 throughout", db_valid, db_data);
    else pass_cnt++;
    wait_db(32'd1);
    wait_db(32'd4);
    chk_cnt++;
    if (cmd_count !== 16'd20) $display("FAIL coal_cmd: got %0d required 20", cmd_count); else pass_cnt++;
    do_read(4'd3, 1'b1, d);
    chk_cnt++;
    if (d !== pat(307)) $display("FAIL coal_rd3: got %h required %h", d, pat(307)); else pass_cnt++;
  endtask

  task automatic test_link_drop();
    logic [255:0] d;
    int unsigned n = 0;
    send_sqe(400);
    while (!db_valid && n < 20) begin
      tick();
      n++;
    end
    send_beat(pat(402));
    lnk = 1'b0;
    repeat (2) tick();
    chk_cnt++;
    if ({db_valid, csr_ioq_ready} !== 2'b00) $display("FAIL link_down: dbv/rdy=%b required 00", {db_valid, csr_ioq_ready});
    else pass_cnt++;
    chk_cnt++;
    if (cmd_count !== 16'd21) $display("FAIL link_cmd: got %0d required 21", cmd_count); else pass_cnt++;
    lnk = 1'b1;
    repeat (2) tick();
    chk_cnt++;
    if (db_valid !== 1'b0) $display("FAIL link_no_db: got %b required 0", db_valid); else pass_cnt++;
    send_sqe(410);
    chk_cnt++;
    if (cmd_count !== 16'd22) $display("FAIL link_cmd2: got %0d required 22", cmd_count); else pass_cnt++;
    wait_db(32'd6);
    do_read(4'd5, 1'b0, d);
    chk_cnt++;
    if (d !== pat(410)) $display("FAIL link_rd5b0: got %h required %h", d, pat(410)); else pass_cnt++;
    do_read(4'd5, 1'b1, d);
    chk_cnt++;
    if (d !== pat(411)) $display("FAIL link_rd5b1: got %h required %h", d, pat(411)); else pass_cnt++;
  endtask

  task automatic test_coincident();
    send_beat(pat(500));
    cq_sq_head_valid = 1'b1;
    cq_sq_head       = 4'd8;
    send_beat(pat(501));
    cq_sq_head_valid = 1'b0;
    chk_cnt++;
    if ({sq_full, sq_empty, csr_ioq_ready} !== 3'b100)
      $display("FAIL coin_flags: full/empty/rdy=%b required 100", {sq_full, sq_empty, csr_ioq_ready});
    else pass_cnt++;
    chk_cnt++;
    if (cmd_count !== 16'd23) $display("FAIL coin_cmd: got %0d required 23", cmd_count); else pass_cnt++;
    wait_db(32'd7);
    cq_sq_head_valid = 1'b1;
    cq_sq_head       = 4'd7;
    tick();
    cq_sq_head_valid = 1'b0;
    chk_cnt++;
    if ({sq_full, sq_empty} !== 2'b01) $display("FAIL coin_drain: full/empty=%b required 01", {sq_full, sq_empty});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    send_beat(pat(600));
    #3;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({cmd_count, sq_empty, sq_full, overflow_err, db_valid} !== {16'd0, 4'b1000})
      $display("FAIL areset: cmd=%0d empty/full/ovf/dbv=%b required 0/1000",
               cmd_count, {sq_empty, sq_full, overflow_err, db_valid});
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    send_sqe(700);
    chk_cnt++;
    if (cmd_count !== 16'd1) $display("FAIL areset_cmd: got %0d required 1", cmd_count); else pass_cnt++;
    wait_db(32'd1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_head_update();
    test_coalesce();
    test_link_drop();
    test_coincident();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
